// File: rtl/blit_arbiter.sv
// Two-requester arbiter in front of a single blitter: latches the winning request's
// parameters, issues one enable pulse and returns a done pulse with the collision result.
// Optional macro BLIT_ARB_RR_EN selects round-robin arbitration (default: fixed priority, r0 wins).
module blit_arbiter #(
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        res,
    input  logic        r0_req,
    input  logic        r1_req,
    input  logic [2:0]  r0_op,
    input  logic [2:0]  r1_op,
    input  logic [11:0] r0_src,
    input  logic [11:0] r1_src,
    input  logic [3:0]  r0_height,
    input  logic [3:0]  r1_height,
    input  logic [6:0]  r0_x,
    input  logic [6:0]  r1_x,
    input  logic [5:0]  r0_y,
    input  logic [5:0]  r1_y,
    output logic        r0_done,
    output logic        r1_done,
    output logic        r0_collision,
    output logic        r1_collision,
    output logic [2:0]  blit_op,
    output logic [11:0] blit_src,
    output logic [3:0]  blit_srcHeight,
    output logic [6:0]  blit_destX,
    output logic [5:0]  blit_destY,
    output logic        blit_enable,
    input  logic        blit_ready,
    input  logic        blit_collision,
    output logic        busy,
    output logic        grant
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

    localparam logic [4:0] TIMEOUT_CNT = 5'(BUSY_TIMEOUT);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_grant;
    logic        r_busy;
    logic        r_enable;
    logic        r_done0;
    logic        r_done1;
    logic        r_col0;
    logic        r_col1;
    logic [2:0]  r_op;
    logic [11:0] r_src;
    logic [3:0]  r_height;
    logic [6:0]  r_x;
    logic [5:0]  r_y;

    logic        w_start;
    logic        w_winner;
    logic [4:0]  w_cnt_inc;

    assign w_start   = (r0_req | r1_req) & blit_ready;
    assign w_cnt_inc = {1'b0, r_cnt} + 5'd1;

`ifdef BLIT_ARB_RR_EN
    // r_ptr names the requester favoured on a tie; it flips away from each finished owner.
    logic r_ptr;
    assign w_winner = (r0_req & r1_req) ? r_ptr : r1_req;
`else
    assign w_winner = ~r0_req;
`endif

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_grant  <= 1'b0;
            r_busy   <= 1'b0;
            r_enable <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_col0   <= 1'b0;
            r_col1   <= 1'b0;
            r_op     <= 3'd0;
            r_src    <= 12'd0;
            r_height <= 4'd0;
            r_x      <= 7'd0;
            r_y      <= 6'd0;
`ifdef BLIT_ARB_RR_EN
            r_ptr    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_op     <= w_winner ? r1_op     : r0_op;
                        r_src    <= w_winner ? r1_src    : r0_src;
                        r_height <= w_winner ? r1_height : r0_height;
                        r_x      <= w_winner ? r1_x      : r0_x;
                        r_y      <= w_winner ? r1_y      : r0_y;
                        r_grant  <= w_winner;
                        if (w_winner) r_col1 <= 1'b0;
                        else          r_col0 <= 1'b0;
                        r_enable <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_enable <= 1'b0;
                    r_cnt    <= 4'd0;
                    r_state  <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // A blit that never drops ready is treated as already finished.
                    if (!blit_ready || (w_cnt_inc >= TIMEOUT_CNT)) begin
                        r_state <= WAIT_DONE;
                    end else if (!w_cnt_inc[4]) begin
                        r_cnt <= w_cnt_inc[3:0];
                    end
                end
                WAIT_DONE: begin
                    if (blit_ready) begin
                        if (r_grant) begin
                            r_col1  <= blit_collision;
                            r_done1 <= 1'b1;
                        end else begin
                            r_col0  <= blit_collision;
                            r_done0 <= 1'b1;
                        end
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    r_busy  <= 1'b0;
`ifdef BLIT_ARB_RR_EN
                    r_ptr   <= ~r_grant;
`endif
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign r0_done        = r_done0;
    assign r1_done        = r_done1;
    assign r0_collision   = r_col0;
    assign r1_collision   = r_col1;
    assign blit_op        = r_op;
    assign blit_src       = r_src;
    assign blit_srcHeight = r_height;
    assign blit_destX     = r_x;
    assign blit_destY     = r_y;
    assign blit_enable    = r_enable;
    assign busy           = r_busy;
    assign grant          = r_grant;

endmodule

// File: doc/blit_arbiter.md
BLIT_ARBITER -- requirements
Module: blit_arbiter

Interface
REQ-001 SHALL have parameter BUSY_TIMEOUT, default 8: max cycles waited in WAIT_BUSY for blit_ready to fall.
REQ-002 SHALL have clk  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have res  input  1  asynchronous, active-low reset.
REQ-004 SHALL have r0_req, r1_req  input  1 each  requester N holds high until its rN_done.
REQ-005 SHALL have r0_op, r1_op  input  3 each  blit operation.
REQ-006 SHALL have r0_src, r1_src  input  12 each  source address.
REQ-007 SHALL have r0_height, r1_height  input  4 each  source height.
REQ-008 SHALL have r0_x, r1_x  input  7 each; r0_y, r1_y  input  6 each  destination.
REQ-009 SHALL have r0_done, r1_done  output  1 each  one-cycle completion pulse.
REQ-010 SHALL have r0_collision, r1_collision  output  1 each  collision result, valid from done pulse until next grant to that requester.
REQ-011 SHALL have blit_op 3, blit_src 12, blit_srcHeight 4, blit_destX 7, blit_destY 6  outputs  latched parameters to blitter.
REQ-012 SHALL have blit_enable  output  1; blit_ready  input  1; blit_collision  input  1.
REQ-013 SHALL have busy  output  1 (state != IDLE); grant  output  1 (id of current/last owner).

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
REQ-015 IDLE: SHALL move to ISSUE when any rN_req is high and blit_ready is high; requests SHALL be ignored while blit_ready is low.
REQ-016 On leaving IDLE, SHALL latch the winner's op/src/height/x/y into blit_* outputs and set grant; outputs SHALL hold stable until the next grant.
REQ-017 ISSUE: SHALL assert blit_enable for exactly one cycle, then enter WAIT_BUSY.
REQ-018 WAIT_BUSY: SHALL enter WAIT_DONE on blit_ready low, or after BUSY_TIMEOUT cycles without it (zero-length blit).
REQ-019 WAIT_DONE: SHALL enter RESP on first cycle blit_ready is high.
REQ-020 RESP: SHALL sample blit_collision into rN_collision of the granted requester, pulse its rN_done one cycle, return to IDLE.
REQ-021 Minimum request-to-done latency SHALL be 4 cycles plus blitter busy time; back-to-back grants SHALL be separated by at least one IDLE cycle.
REQ-022 A requester dropping rN_req after grant SHALL NOT abort the blit; done SHALL still pulse.
REQ-023 The timeout counter SHALL be 4 bits and saturate; it SHALL clear on entering WAIT_BUSY.
REQ-024 A requester with req still high in the cycle after its done SHALL be treated as a new request.

Reset
REQ-025 On res low: state IDLE, blit_enable 0, rN_done 0, rN_collision 0, busy 0, grant 0, blit_* 0, timeout counter 0, priority pointer 0.
REQ-026 Reset mid-blit SHALL abandon the transfer with no done pulse; after release, arbitration SHALL wait for blit_ready high.

Configuration
REQ-027 With BLIT_ARB_RR_EN defined: round-robin; on simultaneous requests the requester not granted last SHALL win; pointer updates at RESP.
REQ-028 Without BLIT_ARB_RR_EN: fixed priority, r0 SHALL always win simultaneous requests; no pointer register.

Verification
REQ-029 r0_req, op=1 src=0x200 h=5 x=10 y=3, blitter busy 20 cycles -> blit_* latched, one enable pulse, r0_done pulses once, r0_collision = blit_collision (1).
REQ-030 r0_req and r1_req same cycle, both held -> RR: r0, r1, r0 order; fixed: r0 continuously, r1 starved.
REQ-031 blit_ready never falls after enable -> RESP after 8+ cycles (BUSY_TIMEOUT=8), done pulses, no hang.
REQ-032 res low during WAIT_DONE -> all outputs zero next cycle, no done; blit_ready held low after release -> no enable issued until it rises.
REQ-033 r1_req dropped one cycle after grant -> blit completes, r1_done pulses, r0 unaffected.
